serial_subtractor: RTL

- Bit-serial, LSB-first subtractor that computes diff = a - b - bin over WIDTH clock cycles.
- It is the inverse-operation counterpart of the team's combinational ripple adder.
- It uses one full-subtractor cell plus shift registers, so it suits area-constrained datapaths.
- A start/busy/done handshake lets a controller or testbench sequence operations.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_full_subtractor.sv | 28 ++
 rtl/serial_subtractor.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // 2'd3 is unused; the FSM falls back to ST_IDLE if it ever appears.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtractor cell built from two half subtractors and an OR gate,
// mirroring the half-cell composition of the ripple adder.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);
   assign d  = x ^ y;
   assign bo = ~x & y;
endmodule

module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic d,
   output logic bo
);
   logic w_d1;
   logic w_b1;
   logic w_b2;

   half_subtractor u_hs_xy (.x(x),    .y(y), .d(w_d1), .bo(w_b1));
   half_subtractor u_hs_z  (.x(w_d1), .y(z), .d(d),    .bo(w_b2));

   assign bo = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH shift cycles,
// using a single full_subtractor cell and operand shift registers.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic [1:0]       dbg_state
);
   // Handshake: start is honoured only in IDLE, where a/b/bin are captured on
   // that edge; busy covers SHIFT and DONE; done pulses for one cycle when
   // diff/bout are valid, and they stay valid until the next accepted start.

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_bout;
   logic [CNT_W-1:0] r_cnt;
   logic             w_d;
   logic             w_bo;
   logic             w_last;

   full_subtractor u_fs (
      .x (r_a_sh[0]),
      .y (r_b_sh[0]),
      .z (r_borrow),
      .d (w_d),
      .bo(w_bo)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_SHIFT;
         ST_SHIFT: if (w_last) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_borrow <= bin;
                  r_cnt    <= '0;
                  r_diff   <= '0;
               end
            end
            ST_SHIFT: begin
               // New bits enter at the MSB so the result is LSB-aligned after WIDTH shifts.
               r_diff   <= {w_d, r_diff[WIDTH-1:1]};
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) r_bout <= w_bo;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         ST_SHIFT: busy = 1'b1;
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign diff      = r_diff;
   assign bout      = r_bout;
   assign dbg_state = r_state;

endmodule
